// File: rtl/runtime_feature_pkg.sv
// Shared types and constants for the runtime feature-enable controller:
// FSM state encoding, feature bit positions and the default dependency table.
package runtime_feature_pkg;

    typedef enum logic [1:0] {
        RF_IDLE  = 2'd0,
        RF_FLUSH = 2'd1,
        RF_DRAIN = 2'd2,
        RF_APPLY = 2'd3
    } rf_state_e;

    localparam int unsigned NrFeatDefault = 32'd16;

    localparam int unsigned FeatRVC    = 32'd0;
    localparam int unsigned FeatRVF    = 32'd1;
    localparam int unsigned FeatRVD    = 32'd2;
    localparam int unsigned FeatZiCond = 32'd3;

    typedef logic [NrFeatDefault-1:0] feat_mask_t;

    // Double precision cannot be enabled without single precision.
    localparam feat_mask_t FeatDepMaskDefault [NrFeatDefault] = '{
        FeatRVD: feat_mask_t'(16'h0001 << FeatRVF),
        default: 16'h0000
    };

endpackage

// File: rtl/rf_drain_timer.sv
// Saturating drain-cycle counter; expired_o is high once the count reaches
// DrainTimeout and stays there until cleared.
module rf_drain_timer #(
    parameter int unsigned DrainTimeout = 32'd255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(DrainTimeout + 32'd1);
    localparam logic [CntW-1:0] CntLimit = CntW'(DrainTimeout);
    localparam logic [CntW-1:0] CntOne   = CntW'(32'd1);

    logic [CntW-1:0] cnt_r;

    // Count while enabled, holding at the limit instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= {CntW{1'b0}};
        end else if (clr_i) begin
            cnt_r <= {CntW{1'b0}};
        end else if (en_i && (cnt_r != CntLimit)) begin
            cnt_r <= cnt_r + CntOne;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired_o = (cnt_r == CntLimit);

endmodule

// File: rtl/runtime_feature_ctrl.sv
// Run-time feature-enable bank; changes are applied only after a pipeline
// flush and drain. Optional write lock is built with RUNTIME_FEATURE_LOCK_EN.
module runtime_feature_ctrl
    import runtime_feature_pkg::*;
#(
    parameter int unsigned            NrFeatures    = 32'd16,
    parameter logic [NrFeatures-1:0]  FeatRstVal    = '1,
    parameter logic [NrFeatures-1:0]  FeatHardwired = '0,
    parameter logic [NrFeatures-1:0]  FeatDepMask [NrFeatures] = '{default: '0},
    parameter int unsigned            DrainTimeout  = 32'd255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [NrFeatures-1:0] wr_data_i,
    input  logic [NrFeatures-1:0] wr_mask_i,
    output logic                  flush_req_o,
    input  logic                  flush_ack_i,
    input  logic                  pipeline_idle_i,
    output logic [NrFeatures-1:0] feat_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
`ifdef RUNTIME_FEATURE_LOCK_EN
    ,
    input  logic                  lock_i
`endif
);

    rf_state_e             state_r, state_nxt_s;
    logic [NrFeatures-1:0] feat_en_r, feat_nxt_s;
    logic [NrFeatures-1:0] pend_r, pend_nxt_s;
    logic [NrFeatures-1:0] eff_s, merged_s, dep_ok_s, cand_s;
    logic                  done_r, done_nxt_s;
    logic                  err_r, err_nxt_s;
    logic                  tmr_clr_s, tmr_en_s, tmr_expired_s;
    logic                  locked_s;

`ifdef RUNTIME_FEATURE_LOCK_EN
    logic lock_r;

    // Sticky lock: once set, only reset releases it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_r <= 1'b0;
        end else if (lock_i) begin
            lock_r <= 1'b1;
        end else begin
            lock_r <= lock_r;
        end
    end

    assign locked_s = lock_r;
`else
    assign locked_s = 1'b0;
`endif

    // Candidate enable set: merge the write, drop features with unmet
    // dependencies, and force hardwired bits back to their reset value.
    always_comb begin
        eff_s    = wr_mask_i & ~FeatHardwired;
        merged_s = (feat_en_r & ~eff_s) | (wr_data_i & eff_s);
        dep_ok_s = {NrFeatures{1'b0}};
        for (int unsigned i = 0; i < NrFeatures; i++) begin
            dep_ok_s[i] = merged_s[i] & ((merged_s & FeatDepMask[i]) == FeatDepMask[i]);
        end
        cand_s = (dep_ok_s & ~FeatHardwired) | (FeatRstVal & FeatHardwired);
    end

    // Next-state and next-register logic of the update sequencer.
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        feat_nxt_s  = feat_en_r;
        done_nxt_s  = 1'b0;
        err_nxt_s   = 1'b0;
        tmr_clr_s   = 1'b0;
        tmr_en_s    = 1'b0;
        case (state_r)
            RF_IDLE: begin
                if (wr_valid_i) begin
                    if (locked_s) begin
                        err_nxt_s = 1'b1;
                    end else if (cand_s == feat_en_r) begin
                        pend_nxt_s = cand_s;
                        done_nxt_s = 1'b1;
                    end else begin
                        pend_nxt_s  = cand_s;
                        state_nxt_s = RF_FLUSH;
                    end
                end else begin
                    state_nxt_s = RF_IDLE;
                end
            end
            RF_FLUSH: begin
                if (flush_ack_i) begin
                    tmr_clr_s   = 1'b1;
                    state_nxt_s = RF_DRAIN;
                end else begin
                    state_nxt_s = RF_FLUSH;
                end
            end
            RF_DRAIN: begin
                // An idle pipeline wins over a timeout in the same cycle.
                if (pipeline_idle_i) begin
                    state_nxt_s = RF_APPLY;
                end else if (tmr_expired_s) begin
                    err_nxt_s   = 1'b1;
                    pend_nxt_s  = {NrFeatures{1'b0}};
                    state_nxt_s = RF_IDLE;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            RF_APPLY: begin
                feat_nxt_s  = pend_r;
                done_nxt_s  = 1'b1;
                state_nxt_s = RF_IDLE;
            end
            default: begin
                state_nxt_s = RF_IDLE;
            end
        endcase
    end

    // State, enable bank, pending value and result pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= RF_IDLE;
            feat_en_r <= FeatRstVal;
            pend_r    <= {NrFeatures{1'b0}};
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            feat_en_r <= feat_nxt_s;
            pend_r    <= pend_nxt_s;
            done_r    <= done_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    rf_drain_timer #(
        .DrainTimeout (DrainTimeout)
    ) u_drain_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (tmr_clr_s),
        .en_i      (tmr_en_s),
        .expired_o (tmr_expired_s)
    );

    assign wr_ready_o  = (state_r == RF_IDLE);
    assign busy_o      = (state_r != RF_IDLE);
    assign flush_req_o = (state_r == RF_FLUSH);
    assign feat_en_o   = feat_en_r;
    assign done_o      = done_r;
    assign err_o       = err_r;

endmodule

// File: tb/tb_runtime_feature_ctrl.sv
// Self-checking bench for runtime_feature_ctrl: directed scenarios plus random
// writes against a transaction-level model. Lock tests need RUNTIME_FEATURE_LOCK_EN.
module tb_runtime_feature_ctrl;
    import runtime_feature_pkg::*;

    localparam logic [15:0] RstVal = 16'hFFFF;
    localparam logic [15:0] HwMask = 16'h0001;
    localparam int          Dt     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = 16'h0000;
    logic [15:0] wr_mask = 16'h0000;
    logic        flush_req;
    logic        flush_ack = 1'b0;
    logic        pipe_idle = 1'b0;
    logic [15:0] feat_en;
    logic        busy, done, err;
`ifdef RUNTIME_FEATURE_LOCK_EN
    logic        lock = 1'b0;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] model_feat = RstVal;
    bit          model_locked = 1'b0;

    runtime_feature_ctrl #(
        .NrFeatures    (16),
        .FeatRstVal    (RstVal),
        .FeatHardwired (HwMask),
        .FeatDepMask   (FeatDepMaskDefault),
        .DrainTimeout  (Dt)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .wr_valid_i      (wr_valid),
        .wr_ready_o      (wr_ready),
        .wr_data_i       (wr_data),
        .wr_mask_i       (wr_mask),
        .flush_req_o     (flush_req),
        .flush_ack_i     (flush_ack),
        .pipeline_idle_i (pipe_idle),
        .feat_en_o       (feat_en),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err)
`ifdef RUNTIME_FEATURE_LOCK_EN
        ,
        .lock_i          (lock)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Feature-level reference: a feature ends up on only if it is requested
    // and every feature it lists as a prerequisite is also requested.
    function automatic logic [15:0] model_write(input logic [15:0] cur, input logic [15:0] data,
                                                input logic [15:0] mask);
        logic [15:0] want;
        logic [15:0] res;
        for (int i = 0; i < 16; i++) begin
            if (HwMask[i]) want[i] = RstVal[i];
            else if (mask[i]) want[i] = data[i];
            else want[i] = cur[i];
        end
        for (int i = 0; i < 16; i++) begin
            bit ok;
            ok = want[i];
            for (int j = 0; j < 16; j++) begin
                if (FeatDepMaskDefault[i][j] && !want[j]) ok = 1'b0;
            end
            res[i] = HwMask[i] ? RstVal[i] : ok;
        end
        return res;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_feat   = RstVal;
        model_locked = 1'b0;
    endtask

    // One write transaction: flush acknowledged ack_dly cycles into FLUSH,
    // pipeline reports idle idle_dly cycles into DRAIN.
    task automatic run_write(input string tag, input logic [15:0] data, input logic [15:0] mask,
                             input int ack_dly, input int idle_dly);
        logic [15:0] exp_new;
        bit          noop, tmo;
        int          d, e;
        bit          exp_done, exp_err;
        exp_new = model_write(model_feat, data, mask);
        noop    = model_locked || (exp_new == model_feat);
        d       = 2 + ack_dly;
        tmo     = !noop && (idle_dly > Dt);
        if (noop) e = 1;
        else if (tmo) e = d + Dt + 1;
        else e = d + idle_dly + 2;

        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = data; wr_mask = mask;
        flush_ack = 1'b0; pipe_idle = 1'b0;
        @(negedge clk);
        check_eq({tag, "_ready0"}, 32'(wr_ready), 32'd1);
        for (int c = 1; c <= e; c++) begin
            @(posedge clk); #1;
            wr_valid  = 1'b0;
            wr_data   = 16'($urandom);
            wr_mask   = 16'($urandom);
            flush_ack = (c >= 1 + ack_dly);
            pipe_idle = (c >= d + idle_dly);
            @(negedge clk);
            exp_done = (c == e) && !model_locked && !tmo;
            exp_err  = (c == e) && (model_locked || tmo);
            check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
            check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
            check_eq({tag, "_flush"}, 32'(flush_req), 32'(!noop && c <= 1 + ack_dly));
            check_eq({tag, "_busy"}, 32'(busy), 32'(!noop && c < e));
            check_eq({tag, "_ready"}, 32'(wr_ready), 32'(noop || c >= e));
            check_eq({tag, "_feat"}, 32'(feat_en),
                     32'((c == e && !noop && !tmo) ? exp_new : model_feat));
        end
        if (!noop && !tmo) model_feat = exp_new;
        flush_ack = 1'b0;
        pipe_idle = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check_eq("rst_feat", 32'(feat_en), 32'hFFFF);
        check_eq("rst_ready", 32'(wr_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_flush", 32'(flush_req), 32'd0);

        run_write("clr_all", 16'h0000, 16'hFFFF, 0, 0);
        check_eq("clr_all_val", 32'(feat_en), 32'h0001);

        run_write("noop", 16'h0000, 16'h0000, 0, 0);
        check_eq("noop_val", 32'(feat_en), 32'h0001);

        run_write("set_all", 16'hFFFF, 16'hFFFF, 1, 2);
        run_write("dep", 16'hFFFD, 16'h0006, 0, 1);
        check_eq("dep_rvd", 32'(feat_en[FeatRVD]), 32'd0);
        check_eq("dep_val", 32'(feat_en), 32'hFFF9);

        run_write("tmo", 16'h0000, 16'hFFFF, 1, 10);
        check_eq("tmo_val", 32'(feat_en), 32'hFFF9);
        run_write("tmo_edge", 16'h0000, 16'hFFFF, 0, Dt);
        check_eq("tmo_edge_val", 32'(feat_en), 32'h0001);

        // Reset while the controller sits in DRAIN.
        @(posedge clk); #1;
        wr_valid = 1'b1; wr_data = 16'h00F0; wr_mask = 16'hFFFF;
        flush_ack = 1'b1; pipe_idle = 1'b0;
        @(posedge clk); #1 wr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_feat", 32'(feat_en), 32'(RstVal));
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_ready", 32'(wr_ready), 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        flush_ack = 1'b0;
        model_feat = RstVal;
        model_locked = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("post_rst_done", 32'(done), 32'd0);
            check_eq("post_rst_err", 32'(err), 32'd0);
            check_eq("post_rst_feat", 32'(feat_en), 32'(RstVal));
        end

`ifdef RUNTIME_FEATURE_LOCK_EN
        @(posedge clk); #1 lock = 1'b1;
        @(posedge clk); #1 lock = 1'b0;
        model_locked = 1'b1;
        run_write("locked", 16'h0000, 16'hFFFF, 0, 0);
        check_eq("locked_val", 32'(feat_en), 32'hFFFF);
        do_reset();
        run_write("unlocked", 16'h0000, 16'hFFFF, 0, 0);
        check_eq("unlocked_val", 32'(feat_en), 32'h0001);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [15:0] rd, rm;
            rd = 16'($urandom);
            rm = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            run_write("rand", rd, rm, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
